// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//   Shares one byte-wide SPI serializer among NREQ requesters. A round-robin
//   arbiter picks a requester in IDLE, the winning byte is loaded with a
//   one-cycle tx_start, the block then waits for tx_done (guarded by a
//   watchdog) and finally holds an inter-frame gap before arbitrating again.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   req        in   [NREQ-1:0]   request levels, held until granted
//   req_data   in   [8*NREQ-1:0] byte of requester i on [8i+7:8i]
//   gnt        out  [NREQ-1:0]   one-hot, one-cycle grant pulse
//   tx_data    out  [7:0]        byte presented to the serializer
//   tx_start   out               one-cycle serializer start pulse
//   tx_done    in                one-cycle completion pulse from serializer
//   busy       out               high in every state except IDLE
//   active_id  out  [IDW-1:0]    requester being served
//   err        out               one-cycle pulse on watchdog timeout
module spi_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_done,
  output logic                busy,
  output logic [IDW-1:0]      active_id,
  output logic                err
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [WW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;

  logic            any_req;
  logic            upper_found;
  logic [IDW-1:0]  upper_id;
  logic [IDW-1:0]  lower_id;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      win_data;

  // Round-robin pick: the lowest set request at or above the pointer wins;
  // if there is none, the lowest set request overall (the wrap-around case).
  // Scanning downward and overwriting leaves the lowest index in each pick.
  always_comb begin
    any_req     = |req;
    upper_found = 1'b0;
    upper_id    = '0;
    lower_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lower_id = IDW'(i);
        if (i >= int'(ptr)) begin
          upper_found = 1'b1;
          upper_id    = IDW'(i);
        end
      end
    end
    win_id     = upper_found ? upper_id : lower_id;
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_id) begin
        win_onehot[i] = 1'b1;
        win_data      = req_data[8*i +: 8];
      end
    end
  end

  // Frame sequencer. gnt, tx_start and err are pulses and default low every
  // cycle; tx_data and active_id hold until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      active_id <= '0;
      err       <= 1'b0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= win_onehot;
            tx_start  <= 1'b1;
            tx_data   <= win_data;
            active_id <= win_id;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Completion has priority over a coinciding watchdog expiry.
          if (tx_done || (wait_cnt == WAIT_LAST)) begin
            err     <= !tx_done;
            ptr     <= (active_id == LAST_ID) ? '0 : active_id + 1'b1;
            gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb_spi_tx_scheduler
//   Directed bench for spi_tx_scheduler: a table of single frames that walks
//   the round-robin pointer, plus hand-written multi-cycle sequences for
//   contention, timeout, done/timeout collision, zero gap and reset mid-frame.
//   A second instance with GAP_CYCLES=0 covers the back-to-back case.
module tb_spi_tx_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int GAP  = 2;
  localparam int TMO  = 32;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic [1:0]  active_id;
  logic        err;

  logic [3:0]  z_req;
  logic [31:0] z_req_data;
  logic [3:0]  z_gnt;
  logic [7:0]  z_tx_data;
  logic        z_tx_start;
  logic        z_tx_done;
  logic        z_busy;
  logic [1:0]  z_active_id;
  logic        z_err;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  spi_tx_scheduler #(
    .NREQ(NREQ), .IDW(IDW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
    .active_id(active_id), .err(err)
  );

  spi_tx_scheduler #(
    .NREQ(NREQ), .IDW(IDW), .GAP_CYCLES(0), .TIMEOUT(TMO)
  ) u_dut_gap0 (
    .clk(clk), .rst(rst), .req(z_req), .req_data(z_req_data), .gnt(z_gnt),
    .tx_data(z_tx_data), .tx_start(z_tx_start), .tx_done(z_tx_done), .busy(z_busy),
    .active_id(z_active_id), .err(z_err)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Pulse tx_done so that it is sampled n edges from now.
  task automatic sendDone(input bit sel, input int n);
    repeat (n - 1) step();
    if (sel) z_tx_done = 1'b1;
    else     tx_done   = 1'b1;
    step();
    z_tx_done = 1'b0;
    tx_done   = 1'b0;
  endtask

  // Steps until tx_start is seen; cycles stays -1 if the bound expires.
  task automatic waitStart(input bit sel, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      if (cycles < 0) begin
        step();
        if ((sel ? z_tx_start : tx_start) === 1'b1) cycles = i;
      end
    end
  endtask

  task automatic resetDut();
    rst = 1'b0;
    req = '0; req_data = '0; tx_done = 1'b0;
    z_req = '0; z_req_data = '0; z_tx_done = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // One table frame: request, check the grant, complete after 8 cycles and
  // check that busy falls exactly GAP cycles after the done edge.
  task automatic applyStimulus(input vec_t v);
    checkOutput("idle_busy", busy, 1'b0);
    req      = v.req;
    req_data = v.data;
    step();
    checkOutput("tbl_gnt", gnt, v.exp_gnt);
    checkOutput("tbl_start", tx_start, 1'b1);
    checkOutput("tbl_data", tx_data, v.exp_data);
    checkOutput("tbl_id", active_id, v.exp_id);
    checkOutput("tbl_busy", busy, 1'b1);
    req = '0;
    step();
    checkOutput("tbl_gnt_pulse", gnt, 4'b0000);
    checkOutput("tbl_start_pulse", tx_start, 1'b0);
    sendDone(1'b0, 7);
    for (int g = 1; g < GAP; g++) begin
      step();
      checkOutput("tbl_gap_busy", busy, 1'b1);
    end
    step();
    checkOutput("tbl_busy_drop", busy, 1'b0);
    checkOutput("tbl_err", err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int cyc;
    int errEarly;
    int ids[4];
    logic [1:0] prevId;

    vecs[0] = '{4'b0100, 32'h44A52211, 4'b0100, 2'd2, 8'hA5};
    vecs[1] = '{4'b0011, 32'h99883C5D, 4'b0001, 2'd0, 8'h5D};
    vecs[2] = '{4'b1001, 32'hE7000001, 4'b1000, 2'd3, 8'hE7};
    vecs[3] = '{4'b1010, 32'hF00FC300, 4'b0010, 2'd1, 8'hC3};
    vecs[4] = '{4'b0110, 32'h12345678, 4'b0100, 2'd2, 8'h34};
    vecs[5] = '{4'b0111, 32'hAABBCCDD, 4'b0001, 2'd0, 8'hDD};
    vecs[6] = '{4'b1111, 32'h01020304, 4'b0010, 2'd1, 8'h03};
    vecs[7] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 8'hFF};

    // Reset values before any clock edge.
    rst = 1'b0;
    req = '0; req_data = '0; tx_done = 1'b0;
    z_req = '0; z_req_data = '0; z_tx_done = 1'b0;
    #2;
    checkOutput("rst_gnt", gnt, 4'b0000);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_tx_start", tx_start, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_active_id", active_id, 2'd0);
    checkOutput("rst_err", err, 1'b0);
    step();
    rst = 1'b1;
    step();

    // Table frames; the pointer carries over from one frame to the next.
    for (int k = 0; k < 8; k++) applyStimulus(vecs[k]);

    // All four contend: served 0,1,2,3 with starts 8+GAP+1 cycles apart.
    resetDut();
    req      = 4'b1111;
    req_data = 32'h44332211;
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput("all_gnt", gnt, 32'(1 << k));
      checkOutput("all_data", tx_data, 32'(8'h11 * (k + 1)));
      checkOutput("all_id", active_id, 32'(k));
      if (k == 3) req = '0;
      sendDone(1'b0, 8);
      if (k < 3) begin
        waitStart(1'b0, 20, cyc);
        checkOutput("all_spacing", 32'(8 + cyc), 32'(8 + GAP + 1));
      end
    end
    repeat (GAP + 1) step();

    // Two requesters held continuously alternate 0,3,0,3.
    resetDut();
    ids[0] = 0; ids[1] = 3; ids[2] = 0; ids[3] = 3;
    req      = 4'b1001;
    req_data = 32'hD00000C0;
    step();
    prevId = 2'd0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rr_id", active_id, 32'(ids[k]));
      checkOutput("rr_data", tx_data, (ids[k] == 0) ? 32'hC0 : 32'hD0);
      if (k > 0) checkOutput("rr_repeat", active_id == prevId, 1'b0);
      prevId = active_id;
      if (k == 3) req = '0;
      sendDone(1'b0, 8);
      if (k < 3) begin
        waitStart(1'b0, 20, cyc);
        checkOutput("rr_spacing", cyc, GAP + 1);
      end
    end
    repeat (GAP + 1) step();

    // Timeout: err on the TIMEOUT-th edge after the start, late done ignored,
    // pointer advanced past requester 2 so requester 3 wins over 2.
    resetDut();
    req      = 4'b0100;
    req_data = 32'h88770000;
    step();
    checkOutput("to_gnt", gnt, 4'b0100);
    req = 4'b1100;
    errEarly = 0;
    for (int i = 1; i < TMO; i++) begin
      step();
      if (err !== 1'b0) errEarly++;
    end
    checkOutput("to_err_early", errEarly, 0);
    step();
    checkOutput("to_err", err, 1'b1);
    checkOutput("to_busy", busy, 1'b1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checkOutput("to_err_pulse", err, 1'b0);
    checkOutput("to_late_done_start", tx_start, 1'b0);
    checkOutput("to_late_done_busy", busy, 1'b1);
    waitStart(1'b0, 20, cyc);
    checkOutput("to_regrant_delay", cyc, GAP);
    checkOutput("to_regrant_gnt", gnt, 4'b1000);
    checkOutput("to_regrant_id", active_id, 2'd3);
    checkOutput("to_regrant_data", tx_data, 8'h88);
    req = '0;
    sendDone(1'b0, 8);
    repeat (GAP + 1) step();

    // Done on the timeout edge wins: no err.
    resetDut();
    req      = 4'b0001;
    req_data = 32'h00000042;
    step();
    req = '0;
    sendDone(1'b0, TMO);
    checkOutput("col_err", err, 1'b0);
    checkOutput("col_busy", busy, 1'b1);
    step();
    checkOutput("col_err_after", err, 1'b0);
    repeat (GAP) step();
    checkOutput("col_idle", busy, 1'b0);

    // Zero gap: next start one edge after the done edge.
    z_req      = 4'b0011;
    z_req_data = 32'h0000BEEF;
    step();
    checkOutput("g0_gnt", z_gnt, 4'b0001);
    checkOutput("g0_data", z_tx_data, 8'hEF);
    sendDone(1'b1, 8);
    checkOutput("g0_busy_drop", z_busy, 1'b0);
    waitStart(1'b1, 20, cyc);
    checkOutput("g0_spacing", cyc, 1);
    checkOutput("g0_gnt2", z_gnt, 4'b0010);
    checkOutput("g0_data2", z_tx_data, 8'hBE);
    checkOutput("g0_id2", z_active_id, 2'd1);
    z_req = '0;
    sendDone(1'b1, 8);
    step();

    // Reset mid-WAIT, then a stale done before the next grant.
    resetDut();
    req      = 4'b0100;
    req_data = 32'h005A0000;
    step();
    checkOutput("mid_gnt", gnt, 4'b0100);
    req = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_gnt", gnt, 4'b0000);
    checkOutput("mid_rst_data", tx_data, 8'h00);
    checkOutput("mid_rst_start", tx_start, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_id", active_id, 2'd0);
    checkOutput("mid_rst_err", err, 1'b0);
    step();
    rst     = 1'b1;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checkOutput("mid_stale_busy", busy, 1'b0);
    checkOutput("mid_stale_start", tx_start, 1'b0);
    checkOutput("mid_stale_err", err, 1'b0);
    req      = 4'b0010;
    req_data = 32'h00006600;
    step();
    checkOutput("mid_gnt1", gnt, 4'b0010);
    checkOutput("mid_id1", active_id, 2'd1);
    checkOutput("mid_data1", tx_data, 8'h66);
    req = '0;
    repeat (3) step();
    checkOutput("mid_still_wait", busy, 1'b1);
    checkOutput("mid_no_err", err, 1'b0);
    sendDone(1'b0, 5);
    repeat (GAP) step();
    checkOutput("mid_final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Shares one byte-wide SPI output serializer among NREQ requesters, such as hash-table result ports.
- Arbitrates round-robin between requesters, loads the winning byte into the serializer and starts it.
- Waits for the serializer's completion pulse, then enforces an inter-frame gap.
- A watchdog aborts a transfer if the serializer never reports done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must satisfy 2^IDW >= NREQ.
- GAP_CYCLES, 2, idle cycles between frames (0 allowed).
- TIMEOUT, 32, maximum cycles in WAIT before abort (>= 9).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until granted.
- req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i]; stable while req[i] is high.
- gnt  out  NREQ  one-hot, one-cycle pulse: the byte of requester i has been accepted.
- tx_data  out  8  byte presented to the serializer.
- tx_start  out  1  one-cycle pulse: the serializer loads tx_data and begins shifting.
- tx_done  in  1  one-cycle pulse from the serializer after the last bit.
- busy  out  1  high in every state except IDLE.
- active_id  out  IDW  index of the requester being served; valid while busy.
- err  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=0, tx_data=0, tx_start=0, busy=0, active_id=0, err=0.
  - Round-robin pointer = 0, so requester 0 has top priority first.
  - Wait and gap counters = 0.
- Reset asserted mid-transfer: the frame is abandoned, no gnt/err is issued afterwards, and tx_done arriving after release is ignored.
- State machine: IDLE -> WAIT -> GAP -> IDLE. With GAP_CYCLES=0, WAIT goes directly to IDLE.
- IDLE: if any req bit is sampled high at edge t, the winner w is the first set bit searching upward from the pointer, wrapping NREQ-1 -> 0. At edge t+1 the block registers:
  - gnt[w]=1 and tx_start=1, both for exactly one cycle;
  - tx_data=req_data[w];
  - active_id=w; busy=1; state=WAIT; wait counter=0.
- Request-to-start latency is 1 cycle.
- tx_data and active_id hold until the next grant; the requester may change its data after gnt.
- WAIT: the wait counter increments each cycle.
  - tx_done=1: pointer=(w+1) mod NREQ, then go to GAP (or IDLE if GAP_CYCLES=0).
  - Counter reaches TIMEOUT-1 without tx_done: err pulses one cycle, pointer advances the same way, then GAP or IDLE.
  - tx_done in the same cycle as timeout: done wins and err is not asserted.
- GAP: counts GAP_CYCLES cycles with busy=1, then returns to IDLE. The first new grant is possible GAP_CYCLES+1 edges after tx_done.
- tx_done while in IDLE or GAP is ignored.
- New req edges during WAIT/GAP are not lost; req is a level and is evaluated on return to IDLE.
- A req dropped before its grant is simply not served; no error.
- At most one gnt bit is ever high, and gnt only coincides with tx_start.
- Fairness: a requester holding req continuously is served within NREQ frames.

Test Plan:
1. Single request: reset, req=4'b0100, data for requester 2 = 8'hA5 → one cycle later gnt=4'b0100, tx_start=1, tx_data=8'hA5, active_id=2. Pulse tx_done 8 cycles later → busy drops exactly GAP_CYCLES cycles after tx_done.
2. All contend: req=4'b1111 held with bytes 11/22/33/44, tx_done returned 8 cycles after each start → grants in order 0,1,2,3, tx_data sequence 11,22,33,44, each tx_start separated by 8+GAP_CYCLES+1 cycles.
3. Round-robin: req[0] and req[3] held continuously → grant order 0,3,0,3; requester 0 is never granted twice in a row.
4. Timeout: grant, then tx_done withheld → err pulses once at cycle TIMEOUT-1 of WAIT and the pointer advances. A late tx_done during GAP has no effect, and a pending req is granted afterwards.
5. Done/timeout collision and gap=0: assert tx_done on the timeout cycle → err stays 0. With GAP_CYCLES=0 and req held, the next tx_start comes 1 cycle after tx_done.
6. Reset mid-WAIT: drop rst 3 cycles after tx_start → all outputs 0 immediately. After release with req=4'b0010, requester 1 is granted, and a stale tx_done pulsed before that grant is ignored.
